// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants and helpers for the reg_file_sb register file.
//   - FLAG_Z/FLAG_V/FLAG_N : bit positions inside the flag register
//   - DEF_DATA_W/DEF_DEPTH : default geometry
//   - rd_src_e / rd_sel()  : selects the source of a bypassed read
package reg_file_sb_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_NUM_FLAGS = 3;

  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_BYPASS = 2'd1,
    RD_ARRAY  = 2'd2
  } rd_src_e;

  // Index 0 wins over the bypass so a write to R0 never leaks onto a read port.
  function automatic rd_src_e rd_sel(input logic addr_is_zero, input logic wr_hit);
    rd_src_e sel;
    if (addr_is_zero) begin
      sel = RD_ZERO;
    end else if (wr_hit) begin
      sel = RD_BYPASS;
    end else begin
      sel = RD_ARRAY;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the register file.
//   master (decode + writeback side): drives write, read addresses, issue, flags.
//   slave  (register file): returns read data, hazard bits, busy count, flags.
// Optional debug port fields exist only when REG_FILE_SB_DBG_PORT_EN is defined.
interface reg_file_sb_if #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int NUM_FLAGS = 3
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [ADDR_W-1:0]    rd_addr1;
  logic [ADDR_W-1:0]    rd_addr2;
  logic [DATA_W-1:0]    rd_data1;
  logic [DATA_W-1:0]    rd_data2;
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_dst;
  logic                 src1_busy;
  logic                 src2_busy;
  logic [ADDR_W:0]      busy_cnt;
  logic [NUM_FLAGS-1:0] flag_in;
  logic [NUM_FLAGS-1:0] flag_en;
  logic [NUM_FLAGS-1:0] flag_out;
`ifdef REG_FILE_SB_DBG_PORT_EN
  logic [ADDR_W-1:0]    dbg_addr;
  logic [DATA_W-1:0]    dbg_data;
  logic [DEPTH-1:0]     dbg_busy;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_valid, iss_dst, flag_in, flag_en,
`ifdef REG_FILE_SB_DBG_PORT_EN
    output dbg_addr,
    input  dbg_data, dbg_busy,
`endif
    input  rd_data1, rd_data2, src1_busy, src2_busy, busy_cnt, flag_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_valid, iss_dst, flag_in, flag_en,
`ifdef REG_FILE_SB_DBG_PORT_EN
    input  dbg_addr,
    output dbg_data, dbg_busy,
`endif
    output rd_data1, rd_data2, src1_busy, src2_busy, busy_cnt, flag_out
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_scoreboard: per-register busy bits and outstanding-write counter.
//   clk, rst            : clock, async active-high reset
//   wr_en/wr_addr       : writeback (clears busy)
//   iss_valid/iss_dst   : issue (sets busy, wins over a same-register writeback)
//   rd_addr1/rd_addr2   : source indices under hazard check
//   src1_busy/src2_busy : pending write not resolved by same-cycle bypass
//   busy_cnt            : registered popcount of busy[]
//   busy_vec            : full busy vector (only with REG_FILE_SB_DBG_PORT_EN)
module reg_file_scoreboard #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              src1_busy,
  output logic              src2_busy,
`ifdef REG_FILE_SB_DBG_PORT_EN
  output logic [DEPTH-1:0]  busy_vec,
`endif
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             iss_act_s, wr_act_s, inc_s, dec_s;

  assign iss_act_s = iss_valid && (iss_dst != {ADDR_W{1'b0}});
  assign wr_act_s  = wr_en && (wr_addr != {ADDR_W{1'b0}});
  // A set only counts on a clear bit; a clear only counts when no issue re-arms the same bit.
  assign inc_s = iss_act_s && !busy_q[iss_dst];
  assign dec_s = wr_act_s && busy_q[wr_addr] && !(iss_act_s && (iss_dst == wr_addr));

  // Next busy vector and incremental count.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < DEPTH; r++) begin
      if (iss_valid && (iss_dst == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {DEPTH{1'b0}};
      cnt_q  <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // busy_q[0] is held at 0, so index 0 never reports a hazard.
  assign src1_busy = busy_q[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
  assign src2_busy = busy_q[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));
  assign busy_cnt  = cnt_q;
`ifdef REG_FILE_SB_DBG_PORT_EN
  assign busy_vec  = busy_q;
`endif

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: DEPTH x DATA_W register file with scoreboard and flag register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_file_sb_if.slave (write, two bypassed reads, issue, hazards,
//              busy count, flags; debug read port with REG_FILE_SB_DBG_PORT_EN)
// R0 reads 0, ignores writes and is never busy. Reads return 0 while rst is high.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_FLAGS = DEF_NUM_FLAGS
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    regs_q [DEPTH];
  logic [DATA_W-1:0]    regs_d [DEPTH];
  logic [NUM_FLAGS-1:0] flag_q, flag_d;
  logic [DATA_W-1:0]    rd_data1_s, rd_data2_s;

  // Next register array and flags.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && (bus.wr_addr != {ADDR_W{1'b0}})) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end else begin
      regs_d = regs_q;
    end
    flag_d = (flag_q & ~bus.flag_en) | (bus.flag_in & bus.flag_en);
  end

  // Data array and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
      end
      flag_q <= {NUM_FLAGS{1'b0}};
    end else begin
      regs_q <= regs_d;
      flag_q <= flag_d;
    end
  end

  // Bypassed read ports; forced to 0 during reset so a live wr_data cannot leak.
  always_comb begin
    rd_data1_s = {DATA_W{1'b0}};
    rd_data2_s = {DATA_W{1'b0}};
    if (!rst) begin
      case (rd_sel(bus.rd_addr1 == {ADDR_W{1'b0}}, bus.wr_en && (bus.wr_addr == bus.rd_addr1)))
        RD_ZERO:   rd_data1_s = {DATA_W{1'b0}};
        RD_BYPASS: rd_data1_s = bus.wr_data;
        RD_ARRAY:  rd_data1_s = regs_q[bus.rd_addr1];
        default:   rd_data1_s = {DATA_W{1'b0}};
      endcase
      case (rd_sel(bus.rd_addr2 == {ADDR_W{1'b0}}, bus.wr_en && (bus.wr_addr == bus.rd_addr2)))
        RD_ZERO:   rd_data2_s = {DATA_W{1'b0}};
        RD_BYPASS: rd_data2_s = bus.wr_data;
        RD_ARRAY:  rd_data2_s = regs_q[bus.rd_addr2];
        default:   rd_data2_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rd_data1_s = {DATA_W{1'b0}};
      rd_data2_s = {DATA_W{1'b0}};
    end
  end

  assign bus.rd_data1 = rd_data1_s;
  assign bus.rd_data2 = rd_data2_s;
  assign bus.flag_out = flag_q;

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_dst   (bus.iss_dst),
    .rd_addr1  (bus.rd_addr1),
    .rd_addr2  (bus.rd_addr2),
    .src1_busy (bus.src1_busy),
    .src2_busy (bus.src2_busy),
`ifdef REG_FILE_SB_DBG_PORT_EN
    .busy_vec  (bus.dbg_busy),
`endif
    .busy_cnt  (bus.busy_cnt)
  );

`ifdef REG_FILE_SB_DBG_PORT_EN
  // Raw stored value, no bypass; R0 is stored as 0 and never written.
  assign bus.dbg_data = regs_q[bus.dbg_addr];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb (default build).
module tb_reg_file_sb;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_file_sb_if #(.DATA_W(16), .DEPTH(16), .NUM_FLAGS(3)) bus ();

  reg_file_sb #(.DATA_W(16), .DEPTH(16), .NUM_FLAGS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.iss_valid = 1'b0;
    bus.flag_en   = 3'b000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0000;
    bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd0;
    bus.iss_valid = 1'b0; bus.iss_dst = 4'd0;
    bus.flag_in = 3'b000; bus.flag_en = 3'b000;
    #2;
    chk("rst_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("rst_flag", 32'(bus.flag_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All indices read 0 after reset.
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr1 = 4'(i);
      bus.rd_addr2 = 4'(15 - i);
      #1;
      chk("rd_all1", 32'(bus.rd_data1), 32'd0);
      chk("rd_all2", 32'(bus.rd_data2), 32'd0);
    end

    // Plain write then read.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
    tick(); idle();
    bus.rd_addr1 = 4'd5; #1;
    chk("wr_r5", 32'(bus.rd_data1), 32'h0000BEEF);

    // Same-cycle bypass on both ports.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1234;
    bus.rd_addr1 = 4'd3; bus.rd_addr2 = 4'd3; #1;
    chk("byp1", 32'(bus.rd_data1), 32'h00001234);
    chk("byp2", 32'(bus.rd_data2), 32'h00001234);
    tick(); idle(); #1;
    chk("r3_stored", 32'(bus.rd_data2), 32'h00001234);

    // R0 write ignored and not bypassed.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'hFFFF;
    bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd5; #1;
    chk("r0_nobyp", 32'(bus.rd_data1), 32'd0);
    tick(); idle(); #1;
    chk("r0_stored", 32'(bus.rd_data1), 32'd0);
    chk("r5_keep", 32'(bus.rd_data2), 32'h0000BEEF);

    // Issue R7, then resolve with writeback.
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd7;
    tick(); idle();
    bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd0; #1;
    chk("iss7_busy", 32'(bus.src1_busy), 32'd1);
    chk("iss7_r0", 32'(bus.src2_busy), 32'd0);
    chk("iss7_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0042; #1;
    chk("wb7_busy", 32'(bus.src1_busy), 32'd0);
    chk("wb7_byp", 32'(bus.rd_data1), 32'h00000042);
    tick(); idle(); #1;
    chk("wb7_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("wb7_clr", 32'(bus.src1_busy), 32'd0);

    // Simultaneous issue/writeback on R4: issue wins.
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd4;
    tick(); idle(); #1;
    chk("iss4_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'h0001;
    tick(); idle();
    bus.rd_addr1 = 4'd4; #1;
    chk("same4_busy", 32'(bus.src1_busy), 32'd1);
    chk("same4_cnt", 32'(bus.busy_cnt), 32'd1);

    // Issue R9, then issue R2 with writeback R9: net 0.
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd9;
    tick(); idle(); #1;
    chk("iss9_cnt", 32'(bus.busy_cnt), 32'd2);
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd2;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h0909;
    tick(); idle();
    bus.rd_addr1 = 4'd9; bus.rd_addr2 = 4'd2; #1;
    chk("net0_cnt", 32'(bus.busy_cnt), 32'd2);
    chk("net0_r9", 32'(bus.src1_busy), 32'd0);
    chk("net0_r2", 32'(bus.src2_busy), 32'd1);

    // Re-issue to busy R4: count unchanged.
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd4;
    tick(); idle(); #1;
    chk("reiss_cnt", 32'(bus.busy_cnt), 32'd2);

    // Writeback to non-busy R11: data written, count unchanged.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd11; bus.wr_data = 16'h0055;
    tick(); idle();
    bus.rd_addr1 = 4'd11; #1;
    chk("wbfree_cnt", 32'(bus.busy_cnt), 32'd2);
    chk("wbfree_data", 32'(bus.rd_data1), 32'h00000055);

    // Flags: no bypass, per-bit enables.
    bus.flag_in = 3'b101; bus.flag_en = 3'b001; #1;
    chk("flag_nobyp", 32'(bus.flag_out), 32'd0);
    tick(); idle(); #1;
    chk("flag_z", 32'(bus.flag_out), 32'b001);
    bus.flag_in = 3'b010; bus.flag_en = 3'b110;
    tick(); idle(); #1;
    chk("flag_vn", 32'(bus.flag_out), 32'b011);

    // Build busy_cnt=3 and R1=AAAA, then async reset mid-cycle.
    bus.iss_valid = 1'b1; bus.iss_dst = 4'd6;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'hAAAA;
    tick(); idle();
    bus.rd_addr1 = 4'd1; bus.rd_addr2 = 4'd4; #1;
    chk("pre_cnt", 32'(bus.busy_cnt), 32'd3);
    chk("pre_r1", 32'(bus.rd_data1), 32'h0000AAAA);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'h1111;
    rst = 1'b1; #1;
    chk("arst_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("arst_rd1", 32'(bus.rd_data1), 32'd0);
    chk("arst_src2", 32'(bus.src2_busy), 32'd0);
    chk("arst_flag", 32'(bus.flag_out), 32'd0);
    bus.wr_en = 1'b0; #1;
    rst = 1'b0; #1;
    chk("post_r1", 32'(bus.rd_data1), 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'h5A5A;
    tick(); idle(); #1;
    chk("post_wr", 32'(bus.rd_data1), 32'h00005A5A);
    chk("post_cnt", 32'(bus.busy_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 16x16 register file.
- Provides DEPTH registers of DATA_W bits, two combinational read ports with write-to-read bypass, register 0 hardwired to zero, and an NUM_FLAGS-bit flag register with per-bit enables.
- Adds a per-register scoreboard (busy bits plus an outstanding-write counter) so the decode stage can detect RAW hazards and stall.
- Sits between decode (reads, issue) and writeback (writes, flags).

Parameters:
- DATA_W, 16, register width in bits.
- DEPTH, 16, number of registers; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH), register index width (derived; not overridden).
- NUM_FLAGS, 3, flag register width; bit0=Z, bit1=V(overflow), bit2=N.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination register.
- wr_data  in  DATA_W  writeback data.
- rd_addr1, rd_addr2  in  ADDR_W  read-port source indices.
- rd_data1, rd_data2  out  DATA_W  read data (combinational).
- iss_valid  in  1  decode issues an instruction that will write iss_dst.
- iss_dst  in  ADDR_W  destination of the issuing instruction.
- src1_busy, src2_busy  out  1  rd_addr1/rd_addr2 has a pending write (combinational).
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.
- flag_in  in  NUM_FLAGS  next flag values.
- flag_en  in  NUM_FLAGS  per-bit flag write enables.
- flag_out  out  NUM_FLAGS  current flag values.

Behaviour:
- Reset (async, immediate, any time):
  - all registers = 0; busy[] = 0; busy_cnt = 0; flags = 0.
  - Reads during reset return 0.
  - Reset mid-operation discards all pending scoreboard entries.
- Register 0:
  - Always reads 0.
  - Writes to 0 are ignored and not bypassed.
  - Never marked busy.
- Write:
  - On the clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read:
  - rd_dataN = 0 if rd_addrN==0.
  - Otherwise wr_data if wr_en && wr_addr==rd_addrN (same-cycle bypass).
  - Otherwise reg[rd_addrN].
  - Both ports are independent and may hit the same index.
- Scoreboard, per register r!=0, next busy[r]:
  - Set if iss_valid && iss_dst==r.
  - Else cleared if wr_en && wr_addr==r.
  - Else hold.
  - Simultaneous issue and writeback to the same r: busy stays set (issue wins; the new producer is outstanding).
  - Issue to an already-busy r: stays busy, counter unchanged (single-producer tracking; the last writeback clears it).
  - Writeback to a non-busy r: legal, data written, no counter change.
- busy_cnt:
  - Registered.
  - Equals the popcount of busy[] after each edge.
  - Updated incrementally: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both occur on different registers in the same cycle.
  - Never exceeds DEPTH-1.
- srcN_busy:
  - = busy[rd_addrN] && !(wr_en && wr_addr==rd_addrN).
  - A same-cycle writeback resolves the hazard via the bypass.
  - 0 for index 0.
- Flags:
  - On the edge, for each bit i with flag_en[i]=1, flag[i] <= flag_in[i].
  - flag_out is registered, with no bypass.
- No X propagation: out-of-range indices are impossible because DEPTH is a power of two.

Optional Feature:
- Macro: REG_FILE_SB_DBG_PORT_EN.
- When defined, adds ports:
  - dbg_addr  in  ADDR_W
  - dbg_data  out  DATA_W
  - dbg_busy  out  DEPTH (full busy vector)
- The debug port is a third read port, without bypass, returning the raw stored value (0 for index 0).
- When not defined, these ports do not exist and the logic is absent.

Decomposition:
- Package reg_file_sb_pkg holds:
  - flag bit index constants FLAG_Z=0, FLAG_V=1, FLAG_N=2;
  - default DATA_W/DEPTH localparams;
  - a function computing the bypassed read.
- One natural sub-module: reg_file_scoreboard, containing busy[], busy_cnt, and the srcN_busy logic.
- The data array and flags remain in the top module.

Test Plan:
- Reset then read all indices: rd_data1/2=0, busy_cnt=0, flag_out=0; then write R5=0xBEEF, and next cycle rd_addr1=5 gives 0xBEEF.
- Bypass: wr_en=1, wr_addr=3, wr_data=0x1234, rd_addr1=rd_addr2=3 in the same cycle -> both ports read 0x1234 before the edge; write to R0 of 0xFFFF -> R0 still reads 0.
- Scoreboard: issue dst=7 -> next cycle src1_busy=1 for rd_addr1=7, busy_cnt=1; writeback R7=0x0042 -> src1_busy drops in the same cycle (bypass), busy_cnt=0 after the edge.
- Simultaneous issue dst=4 and writeback R4 -> busy[4] remains 1, busy_cnt unchanged at 1; concurrent issue R2 and writeback R9 (busy) -> busy_cnt net 0.
- Flags: flag_in=3'b101, flag_en=3'b001 -> flag_out=3'b001; then flag_en=3'b110, flag_in=3'b010 -> flag_out=3'b011.
- Async reset asserted mid-cycle with busy_cnt=3 and R1=0xAAAA -> outputs go to 0 immediately without a clock edge; after release, a write proceeds normally.
